// File: rtl/time_fmt_pkg.sv
// Shared types and constants for the time-stamp UART transmitter:
// bit-level FSM states, ASCII glyphs and BCD helpers.
package time_fmt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int unsigned FRAME_LEN = 19;

    // Five bits so that an out-of-range units digit plus one (up to 16)
    // still reads as >9 instead of wrapping to a valid digit.
    typedef logic [4:0] digit_t;

    typedef struct packed {
        digit_t tens;
        digit_t units;
    } digit_pair_t;

    function automatic logic [7:0] digit_to_ascii(input digit_t d);
        if (d > 5'd9) begin
            return ASCII_QMARK;
        end
        return ASCII_ZERO + {3'b000, d};
    endfunction

    function automatic digit_pair_t bcd_inc(input digit_t tens, input digit_t units);
        digit_pair_t r;
        if (units == 5'd9) begin
            r.tens  = tens + 5'd1;
            r.units = '0;
        end else begin
            r.tens  = tens;
            r.units = units + 5'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: baud counter plus shift register with a start/ready
// handshake that allows the next byte to follow the stop bit with no gap.
module uart_tx_byte
    import time_fmt_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // The last stop-bit cycle counts as ready so a new byte starts on the
    // very next edge, keeping consecutive bytes back-to-back.
    assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
    assign tx_o    = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    tx_q  <= 1'b1;
                    if (start_i) begin
                        state_q <= ST_START;
                        shift_q <= data_i;
                        tx_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (start_i) begin
                            state_q <= ST_START;
                            shift_q <= data_i;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/time_uart_tx.sv
// Snapshots a BCD time stamp on send and transmits it over UART as
// "MM/DD HH:MM:SS.dc\r\n"; month and day are converted to one-based.
module time_uart_tx
    import time_fmt_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic       decenasMes,
    input  logic [3:0] unidadesMes,
    input  logic [1:0] decenasDia,
    input  logic [3:0] unidadesDia,
    input  logic [1:0] decenasHora,
    input  logic [3:0] unidadesHora,
    input  logic [3:0] decenasMinuto,
    input  logic [3:0] unidadesMinuto,
    input  logic [2:0] decenasSegundo,
    input  logic [3:0] unidadesSegundo,
    input  logic [3:0] decimas,
    input  logic [3:0] centesimas,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CLKS_RAW     = CLK_HZ / BAUD;
    localparam int unsigned CLKS_PER_BIT = (CLKS_RAW < 2) ? 2 : CLKS_RAW;
    localparam logic [4:0]  LAST_IDX     = 5'(FRAME_LEN - 1);

    localparam int unsigned D_MT = 0,  D_MU = 1,  D_DT = 2,  D_DU = 3;
    localparam int unsigned D_HT = 4,  D_HU = 5,  D_NT = 6,  D_NU = 7;
    localparam int unsigned D_ST = 8,  D_SU = 9,  D_DS = 10, D_CS = 11;

    digit_t      snap_q [12];
    logic        pending_q;
    logic        busy_q;
    logic        done_q;
    logic [4:0]  idx_q;

    digit_pair_t month_d;
    digit_pair_t day_d;
    logic [4:0]  sel_idx;
    logic [7:0]  byte_d;
    logic        byte_start;
    logic        byte_ready;
    logic        accept;

    assign month_d = bcd_inc(5'(decenasMes), 5'(unidadesMes));
    assign day_d   = bcd_inc(5'(decenasDia), 5'(unidadesDia));
    assign accept  = send && !busy_q && !pending_q;

    // Byte 0 is loaded from the pending slot; later bytes follow the index.
    always_comb begin
        sel_idx = pending_q ? 5'd0 : (idx_q + 5'd1);
        byte_d  = ASCII_QMARK;
        case (sel_idx)
            5'd0:  byte_d = digit_to_ascii(snap_q[D_MT]);
            5'd1:  byte_d = digit_to_ascii(snap_q[D_MU]);
            5'd2:  byte_d = ASCII_SLASH;
            5'd3:  byte_d = digit_to_ascii(snap_q[D_DT]);
            5'd4:  byte_d = digit_to_ascii(snap_q[D_DU]);
            5'd5:  byte_d = ASCII_SPACE;
            5'd6:  byte_d = digit_to_ascii(snap_q[D_HT]);
            5'd7:  byte_d = digit_to_ascii(snap_q[D_HU]);
            5'd8:  byte_d = ASCII_COLON;
            5'd9:  byte_d = digit_to_ascii(snap_q[D_NT]);
            5'd10: byte_d = digit_to_ascii(snap_q[D_NU]);
            5'd11: byte_d = ASCII_COLON;
            5'd12: byte_d = digit_to_ascii(snap_q[D_ST]);
            5'd13: byte_d = digit_to_ascii(snap_q[D_SU]);
            5'd14: byte_d = ASCII_DOT;
            5'd15: byte_d = digit_to_ascii(snap_q[D_DS]);
            5'd16: byte_d = digit_to_ascii(snap_q[D_CS]);
            5'd17: byte_d = ASCII_CR;
            5'd18: byte_d = ASCII_LF;
            default: byte_d = ASCII_QMARK;
        endcase
    end

    assign byte_start = pending_q || (busy_q && byte_ready && (idx_q != LAST_IDX));

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= '0;
            for (int unsigned i = 0; i < 12; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (pending_q) begin
                pending_q <= 1'b0;
                busy_q    <= 1'b1;
                idx_q     <= '0;
            end else if (busy_q && byte_ready) begin
                if (idx_q == LAST_IDX) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    idx_q  <= '0;
                end else begin
                    idx_q <= idx_q + 5'd1;
                end
            end else if (accept) begin
                pending_q    <= 1'b1;
                snap_q[D_MT] <= month_d.tens;
                snap_q[D_MU] <= month_d.units;
                snap_q[D_DT] <= day_d.tens;
                snap_q[D_DU] <= day_d.units;
                snap_q[D_HT] <= 5'(decenasHora);
                snap_q[D_HU] <= 5'(unidadesHora);
                snap_q[D_NT] <= 5'(decenasMinuto);
                snap_q[D_NU] <= 5'(unidadesMinuto);
                snap_q[D_ST] <= 5'(decenasSegundo);
                snap_q[D_SU] <= 5'(unidadesSegundo);
                snap_q[D_DS] <= 5'(decimas);
                snap_q[D_CS] <= 5'(centesimas);
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk    (clk),
        .rst    (rst),
        .start_i(byte_start),
        .data_i (byte_d),
        .ready_o(byte_ready),
        .tx_o   (tx)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_time_uart_tx.sv
// Bench for time_uart_tx at CLK_HZ=40, BAUD=10 (4 clocks per bit): table
// vectors, random vectors against a string-level model, and corner sequences.
module tb_time_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 190 * CPB;
    localparam int NBYTES    = 19;
    localparam int CAP_MAX   = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic       decenasMes;
    logic [3:0] unidadesMes;
    logic [1:0] decenasDia;
    logic [3:0] unidadesDia;
    logic [1:0] decenasHora;
    logic [3:0] unidadesHora;
    logic [3:0] decenasMinuto;
    logic [3:0] unidadesMinuto;
    logic [2:0] decenasSegundo;
    logic [3:0] unidadesSegundo;
    logic [3:0] decimas;
    logic [3:0] centesimas;
    logic       tx;
    logic       busy;
    logic       done;

    time_uart_tx #(
        .CLK_HZ(40),
        .BAUD  (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .send           (send),
        .decenasMes     (decenasMes),
        .unidadesMes    (unidadesMes),
        .decenasDia     (decenasDia),
        .unidadesDia    (unidadesDia),
        .decenasHora    (decenasHora),
        .unidadesHora   (unidadesHora),
        .decenasMinuto  (decenasMinuto),
        .unidadesMinuto (unidadesMinuto),
        .decenasSegundo (decenasSegundo),
        .unidadesSegundo(unidadesSegundo),
        .decimas        (decimas),
        .centesimas     (centesimas),
        .tx             (tx),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mt, mu, dt, du, ht, hu, nt, nu, st, su, ds, cs;
    } vec_t;

    typedef struct {
        vec_t  v;
        string s;
    } tv_t;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_b   [NBYTES];
    logic       cap_tx  [CAP_MAX];
    logic       cap_busy[CAP_MAX];
    logic       cap_done[CAP_MAX];
    tv_t        tbl     [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input int mt, mu, dt, du, ht, hu, nt, nu, st, su, ds, cs);
        vec_t v;
        v.mt = mt; v.mu = mu; v.dt = dt; v.du = du; v.ht = ht; v.hu = hu;
        v.nt = nt; v.nu = nu; v.st = st; v.su = su; v.ds = ds; v.cs = cs;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        return mkv($urandom_range(1, 0), $urandom_range(15, 0), $urandom_range(3, 0),
                   $urandom_range(15, 0), $urandom_range(3, 0), $urandom_range(15, 0),
                   $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(7, 0),
                   $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0));
    endfunction

    task automatic apply(input vec_t v);
        decenasMes      = 1'(v.mt);
        unidadesMes     = 4'(v.mu);
        decenasDia      = 2'(v.dt);
        unidadesDia     = 4'(v.du);
        decenasHora     = 2'(v.ht);
        unidadesHora    = 4'(v.hu);
        decenasMinuto   = 4'(v.nt);
        unidadesMinuto  = 4'(v.nu);
        decenasSegundo  = 3'(v.st);
        unidadesSegundo = 4'(v.su);
        decimas         = 4'(v.ds);
        centesimas      = 4'(v.cs);
    endtask

    function automatic logic [7:0] asc(input int d);
        return (d > 9) ? 8'h3F : 8'(8'h30 + d);
    endfunction

    // Reference: one-based month/day by adding one to the units digit with
    // decimal carry, then render the 17 visible characters plus CR LF.
    task automatic build_model(input vec_t v);
        int mt, mu, dt, du;
        mt = v.mt & 1;  mu = (v.mu & 15) + 1;
        dt = v.dt & 3;  du = (v.du & 15) + 1;
        if (mu == 10) begin mu = 0; mt = mt + 1; end
        if (du == 10) begin du = 0; dt = dt + 1; end
        exp_b[0]  = asc(mt);           exp_b[1]  = asc(mu);
        exp_b[2]  = "/";
        exp_b[3]  = asc(dt);           exp_b[4]  = asc(du);
        exp_b[5]  = " ";
        exp_b[6]  = asc(v.ht & 3);     exp_b[7]  = asc(v.hu & 15);
        exp_b[8]  = ":";
        exp_b[9]  = asc(v.nt & 15);    exp_b[10] = asc(v.nu & 15);
        exp_b[11] = ":";
        exp_b[12] = asc(v.st & 7);     exp_b[13] = asc(v.su & 15);
        exp_b[14] = ".";
        exp_b[15] = asc(v.ds & 15);    exp_b[16] = asc(v.cs & 15);
        exp_b[17] = 8'h0D;             exp_b[18] = 8'h0A;
    endtask

    task automatic build_str(input string s);
        for (int i = 0; i < 17; i++) begin
            exp_b[i] = s[i];
        end
        exp_b[17] = 8'h0D;
        exp_b[18] = 8'h0A;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepting edge, then one more edge for the frame to begin.
    task automatic start_send(input string tag);
        send = 1'b1;
        tick();
        send = 1'b0;
        chk({tag, " busy_after_accept"}, int'(busy), 0);
        tick();
    endtask

    // kind 1: send plus new digits; kind 2: rst; kind 3: send. One cycle each.
    task automatic capture(input int n, input int ev_at, input int ev_kind);
        for (int c = 0; c < n; c++) begin
            cap_tx[c]   = tx;
            cap_busy[c] = busy;
            cap_done[c] = done;
            if (c == ev_at) begin
                case (ev_kind)
                    1: begin send = 1'b1; apply(rand_vec()); end
                    2: rst = 1'b1;
                    3: send = 1'b1;
                    default: ;
                endcase
            end else if (c == ev_at + 1) begin
                send = 1'b0;
                rst  = 1'b0;
            end
            tick();
        end
    endtask

    task automatic check_frame(input string tag, input int n);
        int word, blen, dcnt, bafter;
        for (int b = 0; b < NBYTES; b++) begin
            word = 0;
            for (int j = 0; j < 10; j++) begin
                if (cap_tx[(b * 10 + j) * CPB + CPB / 2]) word = word | (1 << j);
            end
            chk($sformatf("%s byte%0d", tag, b), word, (1 << 9) | (int'(exp_b[b]) << 1));
        end
        blen = n;
        for (int c = n - 1; c >= 0; c--) begin
            if (!cap_busy[c]) blen = c;
        end
        chk({tag, " busy_len"}, blen, FRAME_CYC);
        chk({tag, " done_at_end"}, int'(cap_done[FRAME_CYC]), 1);
        dcnt = 0;
        bafter = 0;
        for (int c = 0; c < n; c++) begin
            if (cap_done[c]) dcnt++;
            if (c >= FRAME_CYC && cap_busy[c]) bafter++;
        end
        chk({tag, " done_count"}, dcnt, 1);
        chk({tag, " busy_after_end"}, bafter, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_busy, cnt_low, cnt_done;
        vec_t v;

        tbl[0].v = mkv(0, 8, 2, 9, 2, 3, 5, 9, 5, 9, 9, 9);   tbl[0].s = "09/30 23:59:59.99";
        tbl[1].v = mkv(0, 9, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);   tbl[1].s = "10/10 00:00:00.00";
        tbl[2].v = mkv(1, 1, 1, 0, 1, 12, 3, 4, 0, 5, 6, 7);  tbl[2].s = "12/11 1?:34:05.67";
        tbl[3].v = mkv(1, 0, 3, 0, 1, 2, 0, 0, 0, 0, 0, 0);   tbl[3].s = "11/31 12:00:00.00";
        tbl[4].v = mkv(1, 9, 0, 15, 3, 15, 10, 0, 7, 9, 15, 10);
        tbl[4].s = "20/0? 3?:?0:79.??";

        rst  = 1'b1;
        send = 1'b1;
        apply(tbl[0].v);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset%0d tx", i), int'(tx), 1);
            chk($sformatf("reset%0d busy", i), int'(busy), 0);
            chk($sformatf("reset%0d done", i), int'(done), 0);
        end
        rst  = 1'b0;
        send = 1'b0;
        capture(60, -10, 0);
        cnt_busy = 0;
        cnt_low  = 0;
        for (int c = 0; c < 60; c++) begin
            if (cap_busy[c]) cnt_busy++;
            if (!cap_tx[c]) cnt_low++;
        end
        chk("send_in_reset busy", cnt_busy, 0);
        chk("send_in_reset tx_low", cnt_low, 0);

        for (int t = 0; t < 5; t++) begin
            apply(tbl[t].v);
            build_str(tbl[t].s);
            start_send($sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d tx_start_latency", t), int'(tx), 0);
            capture(800, -10, 0);
            check_frame($sformatf("tbl%0d", t), 800);
        end

        for (int r = 0; r < 4; r++) begin
            v = rand_vec();
            apply(v);
            build_model(v);
            start_send($sformatf("rnd%0d", r));
            capture(800, -10, 0);
            check_frame($sformatf("rnd%0d", r), 800);
        end

        apply(tbl[0].v);
        build_str(tbl[0].s);
        start_send("midframe");
        capture(800, 3 * 10 * CPB + 5, 1);
        check_frame("midframe", 800);

        apply(tbl[1].v);
        start_send("abort");
        capture(400, 5 * 10 * CPB + 10, 2);
        chk("abort tx", int'(cap_tx[5 * 10 * CPB + 11]), 1);
        chk("abort busy", int'(cap_busy[5 * 10 * CPB + 11]), 0);
        cnt_busy = 0;
        cnt_done = 0;
        cnt_low  = 0;
        for (int c = 5 * 10 * CPB + 11; c < 400; c++) begin
            if (cap_busy[c]) cnt_busy++;
            if (!cap_tx[c]) cnt_low++;
        end
        for (int c = 0; c < 400; c++) begin
            if (cap_done[c]) cnt_done++;
        end
        chk("abort busy_after", cnt_busy, 0);
        chk("abort tx_low_after", cnt_low, 0);
        chk("abort done_count", cnt_done, 0);
        build_str(tbl[1].s);
        start_send("after_abort");
        capture(800, -10, 0);
        check_frame("after_abort", 800);

        apply(tbl[3].v);
        build_str(tbl[3].s);
        start_send("b2b_first");
        capture(FRAME_CYC + 2, FRAME_CYC, 3);
        check_frame("b2b_first", FRAME_CYC + 2);
        capture(800, -10, 0);
        check_frame("b2b_second", 800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_uart_tx.md
TIME_UART_TX -- requirements
Module: time_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer division, minimum 2.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port send  input  1  request to snapshot the time and transmit one frame.
REQ-006 SHALL have port decenasMes  input  1  month tens digit, zero-based month 0-11.
REQ-007 SHALL have port unidadesMes  input  4  month units digit, BCD.
REQ-008 SHALL have port decenasDia  input  2  day tens digit, zero-based day 0-30.
REQ-009 SHALL have port unidadesDia  input  4  day units digit, BCD.
REQ-010 SHALL have port decenasHora  input  2  hour tens digit.
REQ-011 SHALL have port unidadesHora  input  4  hour units digit.
REQ-012 SHALL have port decenasMinuto  input  4  minute tens digit.
REQ-013 SHALL have port unidadesMinuto  input  4  minute units digit.
REQ-014 SHALL have port decenasSegundo  input  3  second tens digit.
REQ-015 SHALL have port unidadesSegundo  input  4  second units digit.
REQ-016 SHALL have port decimas  input  4  tenths-of-second digit.
REQ-017 SHALL have port centesimas  input  4  hundredths-of-second digit.
REQ-018 SHALL have port tx  output  1  UART line, 8N1, LSB first, idle high.
REQ-019 SHALL have port busy  output  1  frame in progress.
REQ-020 SHALL have port done  output  1  one-cycle pulse at end of frame.

Function
REQ-021 SHALL accept send only when busy=0; send while busy=1 SHALL be ignored, with no queuing.
REQ-022 SHALL snapshot all 12 digits on the accepting edge; input changes during the frame SHALL NOT affect the frame.
REQ-023 SHALL convert the month and day to one-based BCD at snapshot: units+1, with units 9 becoming 0 and carrying +1 into the tens digit.
REQ-024 SHALL transmit the 19-byte frame "MM/DD HH:MM:SS.dc" followed by 0x0D, 0x0A, in that order, tens digit before units digit.
REQ-025 SHALL encode each digit 0-9 as ASCII 0x30+digit; any digit >9 after conversion SHALL be sent as '?' (0x3F).
REQ-026 SHALL use FSM states IDLE->START->DATA->STOP; after STOP it SHALL go to START if byte index <18, else to IDLE.
REQ-027 SHALL hold each bit for exactly CLKS_PER_BIT cycles; START drives 0, DATA drives bits 0..7, STOP drives 1.
REQ-028 SHALL drive tx low and busy high on the first edge after the accepting edge, i.e. a latency of 1 cycle.
REQ-029 SHALL transmit bytes back-to-back with no idle gap, so a frame lasts exactly 190*CLKS_PER_BIT cycles.
REQ-030 SHALL pulse done for one cycle on the same edge that busy falls; busy=0 and done=1 SHALL coincide.
REQ-031 SHALL accept a send asserted in the cycle after done, with no dead time beyond that cycle.

Reset
REQ-032 SHALL on rst set tx=1, busy=0, done=0, state=IDLE, byte index=0, and baud counter=0, including mid-frame.
REQ-033 SHALL give rst priority over send in the same cycle; no done pulse SHALL follow an aborted frame.

Structure
REQ-034 SHALL place the state enum, the ASCII constants ('0', '/', ' ', ':', '.', '?', CR, LF) and FRAME_LEN=19 in package time_fmt_pkg.
REQ-035 SHALL instantiate one sub-module, uart_tx_byte (baud counter plus shift register, start/ready handshake); frame sequencing and BCD conversion SHALL stay in time_uart_tx.

Verification (bench CLK_HZ=40, BAUD=10, CLKS_PER_BIT=4)
REQ-036 SHALL check: rst held 3 cycles -> tx=1, busy=0, done=0; send asserted during rst -> no frame.
REQ-037 SHALL check: month 0/8, day 2/9, 23:59:59.99, send -> "09/30 23:59:59.99\r\n", 760 cycles, single done pulse.
REQ-038 SHALL check: month 0/9, day 0/9 -> month "10", day "10" (carry path).
REQ-039 SHALL check: second send at byte 3, and all digits changed mid-frame -> frame unchanged, exactly one frame sent.
REQ-040 SHALL check: rst during byte 5 -> tx=1, busy=0 next edge, no done; following send -> full correct frame.
REQ-041 SHALL check: unidadesHora=12 -> byte 7 (zero-based) = 0x3F, all other bytes correct.
